// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared access-state encoding and constants for the memory port arbiter.
package riscv_mem_pkg;
    typedef enum logic [1:0] {IDLE, I_RD, D_RD, D_WR} mem_state_e;
    localparam logic [31:0] OOB_DATA_DEF = 32'hDEADBEEF;
    localparam logic [3:0]  WEN_NONE     = 4'b0000;
    localparam logic [3:0]  WEN_WORD     = 4'b1111;
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: data-first grant selection that yields to a starved instruction fetch.
module mem_arb_prio #(
    parameter int DATA_BURST_MAX = 4,
    parameter int CW             = $clog2(DATA_BURST_MAX + 1)
) (
    input  logic          i_req,
    input  logic          d_req,
    input  logic [CW-1:0] starve_cnt,
    output logic          i_gnt,
    output logic          d_gnt
);
    always_comb begin
        i_gnt = i_req && (!d_req || starve_cnt == CW'(DATA_BURST_MAX));
        d_gnt = d_req && !i_gnt;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-cycle memory between instruction and data ports.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int          MEM_BYTES      = 4096,
    parameter int          DATA_BURST_MAX = 4,
    parameter logic [31:0] OOB_DATA       = OOB_DATA_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_wen,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic [31:0] m_addr,
    output logic [3:0]  m_wen,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);
    localparam int          CW        = $clog2(DATA_BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_BURST_MAX);
    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    mem_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          oob_q, oob_d;
    logic [31:0]   m_addr_q, m_addr_d;
    logic [31:0]   m_wdata_q, m_wdata_d;
    logic          i_win, d_win, in_range;
    logic [31:0]   acc_addr, rd_word;

    mem_arb_prio #(.DATA_BURST_MAX(DATA_BURST_MAX), .CW(CW)) u_prio (
        .i_req      (i_req),
        .d_req      (d_req),
        .starve_cnt (cnt_q),
        .i_gnt      (i_win),
        .d_gnt      (d_win)
    );

    // Grants are masked while in reset so nothing reaches the memory or the state.
    always_comb begin
        i_gnt     = i_win && rst_n;
        d_gnt     = d_win && rst_n;
        acc_addr  = d_gnt ? d_addr : i_addr;
        in_range  = acc_addr < MEM_LIMIT;
        m_addr_d  = (i_gnt || d_gnt) ? acc_addr : m_addr_q;
        m_wdata_d = d_gnt ? d_wdata : m_wdata_q;
        m_addr    = m_addr_d;
        m_wdata   = m_wdata_d;
        m_en      = (i_gnt || d_gnt) && in_range;
        m_wen     = (d_gnt && in_range) ? d_wen : WEN_NONE;
        oob_d     = !in_range;
        state_d   = i_gnt ? I_RD : !d_gnt ? IDLE : (d_wen == WEN_NONE) ? D_RD : D_WR;
        cnt_d     = (!i_req || i_gnt) ? '0 :
                    (d_gnt && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
        i_rvalid  = state_q == I_RD;
        d_rvalid  = state_q == D_RD;
        rd_word   = oob_q ? OOB_DATA : m_rdata;
        i_rdata   = i_rvalid ? rd_word : '0;
        d_rdata   = d_rvalid ? rd_word : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            oob_q     <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            oob_q     <= oob_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks against a behavioural arbiter/memory model.
module tb_mem_port_arbiter;
    localparam int BURST = 4;

    logic        clk, rst_n;
    logic        i_req, d_req;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_wen;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, m_en;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wen;
    int          n_cmp = 0;
    int          n_bad = 0;

    mem_port_arbiter #(.MEM_BYTES(4096), .DATA_BURST_MAX(BURST)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_addr(m_addr), .m_wen(m_wen), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [31:0] seed(input int k);
        return (k == 0) ? 32'h00500093 : (32'(k) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: request captured just before the rising edge, applied on it.
    initial begin
        logic [31:0] tmem [0:1023];
        logic        c_en;
        logic [31:0] c_addr, c_wdata;
        logic [3:0]  c_wen;
        for (int k = 0; k < 1024; k++) tmem[k] = seed(k);
        m_rdata = '0;
        forever begin
            @(negedge clk);
            #8;
            c_en = m_en; c_addr = m_addr; c_wen = m_wen; c_wdata = m_wdata;
            @(posedge clk);
            if (rst_n && c_en) begin
                if (c_wen != 4'b0000) begin
                    for (int b = 0; b < 4; b++)
                        if (c_wen[b]) tmem[c_addr[11:2]][8*b +: 8] = c_wdata[8*b +: 8];
                end else begin
                    m_rdata = tmem[c_addr[11:2]];
                end
            end
        end
    end

    // Reference model and per-cycle compare.
    initial begin
        logic [31:0] refmem [0:1023];
        int          cnt_m;
        bit          pend_i, pend_d, eig, edg, inr;
        logic [31:0] pend_data, last_addr, last_wdata, ea;
        for (int k = 0; k < 1024; k++) refmem[k] = seed(k);
        cnt_m = 0; pend_i = 0; pend_d = 0; pend_data = '0; last_addr = '0; last_wdata = '0;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            if (!rst_n) begin
                chk("rst_i_gnt", i_gnt, 0);
                chk("rst_d_gnt", d_gnt, 0);
                chk("rst_i_rvalid", i_rvalid, 0);
                chk("rst_d_rvalid", d_rvalid, 0);
                chk("rst_m_en", m_en, 0);
                chk("rst_m_wen", m_wen, 0);
                chk("rst_m_addr", m_addr, 0);
                chk("rst_m_wdata", m_wdata, 0);
                chk("rst_i_rdata", i_rdata, 0);
                chk("rst_d_rdata", d_rdata, 0);
                cnt_m = 0; pend_i = 0; pend_d = 0; last_addr = '0; last_wdata = '0;
            end else begin
                eig = i_req && (!d_req || cnt_m == BURST);
                edg = d_req && !eig;
                ea  = edg ? d_addr : i_addr;
                inr = ea < 32'd4096;
                if (eig || edg) last_addr = ea;
                if (edg) last_wdata = d_wdata;
                chk("i_gnt", i_gnt, eig);
                chk("d_gnt", d_gnt, edg);
                chk("m_en", m_en, (eig || edg) && inr);
                chk("m_addr", m_addr, last_addr);
                chk("m_wen", m_wen, (edg && inr) ? d_wen : 4'b0000);
                chk("m_wdata", m_wdata, last_wdata);
                chk("i_rvalid", i_rvalid, pend_i);
                chk("d_rvalid", d_rvalid, pend_d);
                chk("i_rdata", i_rdata, pend_i ? pend_data : 32'h0);
                chk("d_rdata", d_rdata, pend_d ? pend_data : 32'h0);
                pend_i = eig;
                pend_d = edg && d_wen == 4'b0000;
                if (pend_i || pend_d) pend_data = inr ? refmem[ea[11:2]] : 32'hDEADBEEF;
                if (edg && d_wen != 4'b0000 && inr)
                    for (int b = 0; b < 4; b++)
                        if (d_wen[b]) refmem[ea[11:2]][8*b +: 8] = d_wdata[8*b +: 8];
                cnt_m = (!i_req || eig) ? 0 : edg ? ((cnt_m + 1 > BURST) ? BURST : cnt_m + 1) : cnt_m;
            end
        end
    end

    task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                        input logic [3:0] w, input logic [31:0] wd);
        @(posedge clk);
        #1;
        i_req = ir; i_addr = ia; d_req = dr; d_addr = da; d_wen = w; d_wdata = wd;
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #1 rst_n = 1'b0;
        #1 i_req = 1'b0; d_req = 1'b0;
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [9:0] pat;
        bit         ir, dr;
        logic [31:0] ia, da;
        logic [3:0]  w;
        rst_n = 1'b0;
        i_req = 1'b1; d_req = 1'b1; i_addr = '0; d_addr = 32'h44; d_wen = '0; d_wdata = 32'h77;
        @(negedge clk);
        #1;
        chk("rst_gate_i_gnt", i_gnt, 0);
        chk("rst_gate_d_gnt", d_gnt, 0);
        chk("rst_gate_m_addr", m_addr, 0);
        i_req = 1'b0; d_req = 1'b0;
        #2 rst_n = 1'b1;

        step(1, 0, 0, 0, 0, 0);
        chk("fetch_gnt", i_gnt, 1);
        chk("fetch_m_en", m_en, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("fetch_rvalid", i_rvalid, 1);
        chk("fetch_rdata", i_rdata, 32'h00500093);
        chk("fetch_d_rvalid", d_rvalid, 0);

        step(0, 0, 1, 32'h100, 4'b1111, 32'd3);
        chk("wr_gnt", d_gnt, 1);
        chk("wr_m_wen", m_wen, 4'b1111);
        chk("wr_m_addr", m_addr, 32'h100);
        chk("wr_m_wdata", m_wdata, 32'd3);
        step(0, 0, 1, 32'h100, 0, 0);
        chk("wr_no_rvalid", d_rvalid, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("rd_back_rvalid", d_rvalid, 1);
        chk("rd_back_rdata", d_rdata, 32'd3);

        pat = 10'b1000010000;
        for (int k = 0; k < 10; k++) begin
            step(1, 32'h20, 1, 32'h24, 0, 0);
            chk("burst_i_gnt", i_gnt, pat[k]);
            chk("burst_d_gnt", d_gnt, !pat[k]);
        end
        step(0, 0, 0, 0, 0, 0);

        step(0, 0, 1, 32'h2000, 0, 0);
        chk("oob_gnt", d_gnt, 1);
        chk("oob_m_en", m_en, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("oob_rvalid", d_rvalid, 1);
        chk("oob_rdata", d_rdata, 32'hDEADBEEF);
        step(0, 0, 1, 32'h3000, 4'b1111, 32'd5);
        chk("oob_wr_m_en", m_en, 0);
        chk("oob_wr_m_wen", m_wen, 0);

        step(1, 32'h4, 0, 0, 0, 0);
        chk("rstpulse_gnt", i_gnt, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstpulse_m_addr", m_addr, 0);
        chk("rstpulse_i_gnt", i_gnt, 0);
        i_req = 1'b0;
        #1 rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0);
        chk("rstpulse_i_rvalid", i_rvalid, 0);
        chk("rstpulse_d_rvalid", d_rvalid, 0);

        for (int k = 0; k < 8; k++) begin
            step(k % 2 == 0, 32'h8, k % 2 == 1, 32'hC, 0, 0);
            if (k > 0) begin
                chk("alt_i_rvalid", i_rvalid, k % 2 == 1);
                chk("alt_d_rvalid", d_rvalid, k % 2 == 0);
                chk("alt_i_rdata", i_rdata, (k % 2 == 1) ? seed(2) : 32'h0);
                chk("alt_d_rdata", d_rdata, (k % 2 == 0) ? seed(3) : 32'h0);
            end
        end

        for (int k = 0; k < 3000; k++) begin
            ir = $urandom_range(0, 9) < 7;
            dr = $urandom_range(0, 9) < 7;
            ia = 32'($urandom_range(0, 1023)) << 2;
            da = ($urandom_range(0, 7) == 0) ? (32'($urandom_range(1024, 1100)) << 2)
                                             : (32'($urandom_range(0, 1023)) << 2);
            case ($urandom_range(0, 3))
                0, 1:    w = 4'b0000;
                2:       w = 4'b1111;
                default: w = 4'($urandom_range(0, 15));
            endcase
            if (k % 250 == 249) w = 4'b0000;
            step(ir, ia, dr, da, w, $urandom);
            if (k % 250 == 249) pulse_reset();
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
